// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline stages.
//   state_t   : occupancy state of the two-entry skid stage
//   NOP_INSTR : canonical RISC-V NOP (addi x0,x0,0), used as the bubble
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Ports:
//   clk   : rising-edge clock
//   clear : 0 = clear count to zero (synchronous, wins over inc)
//   inc   : add one this cycle unless already at all-ones
//   count : current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between fetch and decode.
// MAIN is the head entry shown on the output; SKID catches one extra beat
// so in_ready can be a pure function of registered state.
//
// Handshake: a beat moves on a port in a cycle where valid and ready are
// both 1 at the rising edge. Here accept = in_valid & in_ready and
// drain = out_valid & out_ready & ~stall; stall only blocks the drain.
// flush empties the stage and drops the same-cycle input beat. reset
// (active low, synchronous) overrides everything.
//
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   in_valid/in_ready     : upstream handshake, with in_pc/in_instr
//   stall, flush          : hazard-unit hold and control-hazard kill
//   out_valid/out_ready   : downstream handshake, with out_pc/out_instr
//   flush_cnt             : saturating count of cycles with flush=1
//   state_dbg             : current occupancy state (debug visibility)
module pipe_skid_stage
  import riscv_pipe_pkg::*;
#(
  parameter int                PC_W         = 32,
  parameter int                INSTR_W      = 32,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(NOP_INSTR),
  parameter int                CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [1:0]         state_dbg
);

  state_t             state;
  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               accept;
  logic               drain;

  // Ready/valid decode from registered state only: no out_ready -> in_ready path.
  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready & ~stall;
  assign state_dbg = state;

  // Entry data is not reset; the EMPTY decode masks it on the outputs.
  assign out_pc    = out_valid ? main_pc    : '0;
  assign out_instr = out_valid ? main_instr : BUBBLE_INSTR;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state      <= ST_ONE;
            main_pc    <= in_pc;
            main_instr <= in_instr;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_pc    <= in_pc;
            main_instr <= in_instr;
          end else if (accept) begin
            state      <= ST_TWO;
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
          end else if (drain) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is 0 here, so only a drain can change anything.
          if (drain) begin
            state      <= ST_ONE;
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .clear(reset),
    .inc  (flush),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [7:0]  flush_cnt;
  logic [1:0]  state_dbg;

  // Second instance with a 4-bit flush counter for the saturation check.
  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_pc4;
  logic [31:0] out_instr4;
  logic [3:0]  flush_cnt4;
  logic [1:0]  state_dbg4;

  int total;
  int bad;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  pipe_skid_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_pc(in_pc), .in_instr(in_instr), .stall(stall), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .out_pc(out_pc4),
    .out_instr(out_instr4), .flush_cnt(flush_cnt4), .state_dbg(state_dbg4)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hABCD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before inputs change / outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                       input logic st, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_ovalid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_iready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_opc"}, out_pc, 32'd0);
    check({tag, "_oinstr"}, out_instr, NOP);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [1:0] st);
    check({tag, "_ovalid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_opc"}, out_pc, pc);
    check({tag, "_oinstr"}, out_instr, instr_of(pc));
    check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, st});
    check({tag, "_iready"}, {31'd0, in_ready}, {31'd0, (st != 2'd2)});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_empty("reset");
    check("reset_cnt", {24'd0, flush_cnt}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b1;

    // Stream with 1-cycle latency
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0); step(); check_head("s0", 32'h0, 2'd1);
    drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0); step(); check_head("s4", 32'h4, 2'd1);
    drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0); step(); check_head("s8", 32'h8, 2'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step(); check_empty("s_end");

    // Backpressure fills SKID, TWO refuses further input
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0); step(); check_head("bp0", 32'h100, 2'd1);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0); step(); check_head("bp1", 32'h100, 2'd2);
    drive(1'b1, 32'h1FC, 1'b0, 1'b0, 1'b0); step(); check_head("bp_hold", 32'h100, 2'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step(); check_head("bp_d0", 32'h104, 2'd1);
    step(); check_empty("bp_end");

    // Stall: fill still allowed, output frozen
    drive(1'b1, 32'h1F0, 1'b1, 1'b0, 1'b0); step(); check_head("st0", 32'h1F0, 2'd1);
    drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b0); step(); check_head("st1", 32'h1F0, 2'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0); step(); check_head("st_frz", 32'h1F0, 2'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step(); check_head("st_d0", 32'h200, 2'd1);
    step(); check_empty("st_end");

    // Flush in TWO with stall and a live input beat
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b0); step(); check_head("fl_pre", 32'h400, 2'd2);
    drive(1'b1, 32'h408, 1'b1, 1'b1, 1'b1); step();
    check_empty("fl");
    check("fl_cnt", {24'd0, flush_cnt}, 32'd1);
    check("fl_state", {30'd0, state_dbg}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step();
    check_empty("fl_after");
    check("fl_cnt_hold", {24'd0, flush_cnt}, 32'd1);

    // Saturation: 20 flush cycles on top of the one above
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step();
      check($sformatf("sat4_%0d", i), {28'd0, flush_cnt4}, (1 + i > 15) ? 32'd15 : 32'(1 + i));
    end
    check("sat8", {24'd0, flush_cnt}, 32'd21);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation in TWO
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h504, 1'b0, 1'b0, 1'b0); step(); check_head("rs_pre", 32'h500, 2'd2);
    reset = 1'b0;
    drive(1'b1, 32'h508, 1'b1, 1'b1, 1'b1); step();
    check_empty("rs");
    check("rs_cnt", {24'd0, flush_cnt}, 32'd0);
    check("rs_cnt4", {28'd0, flush_cnt4}, 32'd0);
    reset = 1'b1;
    drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b0); step(); check_head("rs_new", 32'h300, 2'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step(); check_empty("rs_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
